// File: rtl/byte_arb_pkg.sv
// Shared types and constants for the round-robin byte register arbiter.
// The BYTE_ARB_LOCK_EN macro adds per-requester lock support in the interface and the top.
package byte_arb_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_WIDTH   = 8;

    // A one-requester build still needs a one-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/byte_reg_arbiter_if.sv
// Requester and downstream bundle for byte_reg_arbiter.
// Defining BYTE_ARB_LOCK_EN adds the req_lock vector.
interface byte_reg_arbiter_if
    import byte_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH
);
    localparam int IDX_W = idx_width(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_ready;
`ifdef BYTE_ARB_LOCK_EN
    logic [NUM_REQ-1:0]       req_lock;
`endif
    logic                     out_valid;
    logic [WIDTH-1:0]         out_data;
    logic [IDX_W-1:0]         out_src;
    logic                     out_ready;

`ifdef BYTE_ARB_LOCK_EN
    modport master (
        output req_valid, req_data, req_lock, out_ready,
        input  req_ready, out_valid, out_data, out_src
    );
    modport slave (
        input  req_valid, req_data, req_lock, out_ready,
        output req_ready, out_valid, out_data, out_src
    );
`else
    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_src
    );
    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_src
    );
`endif

endinterface

// File: rtl/byte_reg_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req searching upward from ptr+1.
module rr_pick
    import byte_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    localparam int IDX_W  = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   sel,
    output logic               any_req
);

    // Walk from the farthest candidate back to the nearest so the nearest wins.
    always_comb begin
        sel     = '0;
        any_req = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req[(int'(ptr) + k) % NUM_REQ]) begin
                sel     = IDX_W'((int'(ptr) + k) % NUM_REQ);
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/byte_reg_arbiter.sv
// Round-robin arbiter sharing one registered byte stage between NUM_REQ requesters.
// BYTE_ARB_LOCK_EN lets a requester lock the grant across several beats.
//
//   state | meaning
//   ------+-------------------------------------------
//   EMPTY | output buffer holds no beat
//   FULL  | output buffer holds a beat for downstream
module byte_reg_arbiter
    import byte_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH
) (
    input logic               clk,
    input logic               rst,
    byte_reg_arbiter_if.slave bus
);

    localparam int IDX_W = idx_width(NUM_REQ);
    localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(NUM_REQ - 1);

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   sel;
    logic               any_req;
    logic               can_accept;
    logic               xfer;
    logic [NUM_REQ-1:0] cand;
    logic [WIDTH-1:0]   data_q;
    logic [IDX_W-1:0]   src_q;

`ifdef BYTE_ARB_LOCK_EN
    logic               lock_active;
    logic [IDX_W-1:0]   lock_idx;
    logic [NUM_REQ-1:0] lock_mask;

    assign lock_mask = NUM_REQ'(1) << lock_idx;
    assign cand      = lock_active ? (bus.req_valid & lock_mask) : bus.req_valid;
`else
    assign cand      = bus.req_valid;
`endif

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req     (cand),
        .ptr     (rr_ptr),
        .sel     (sel),
        .any_req (any_req)
    );

    // Draining and refilling in the same cycle keeps full throughput.
    assign can_accept = (state == EMPTY) || (bus.out_ready && (state == FULL));
    assign xfer       = rst && any_req && can_accept;

    always_ff @(posedge clk) begin
        if (!rst) state <= EMPTY;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (xfer) state_nxt = FULL;
            FULL: begin
                if (xfer)               state_nxt = FULL;
                else if (bus.out_ready) state_nxt = EMPTY;
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        if (xfer) bus.req_ready[sel] = 1'b1;
        bus.out_valid = (state == FULL);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            data_q <= '0;
            src_q  <= '0;
            rr_ptr <= PTR_RST;
        end else if (xfer) begin
            data_q <= bus.req_data[int'(sel)*WIDTH +: WIDTH];
            src_q  <= sel;
            rr_ptr <= sel;
        end
    end

`ifdef BYTE_ARB_LOCK_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            lock_active <= 1'b0;
            lock_idx    <= '0;
        end else if (xfer) begin
            if (bus.req_lock[sel]) begin
                lock_active <= 1'b1;
                lock_idx    <= sel;
            end else if (lock_active && (sel == lock_idx)) begin
                lock_active <= 1'b0;
            end
        end
    end
`endif

    assign bus.out_data = data_q;
    assign bus.out_src  = src_q;

endmodule
